// File: rtl/md_pos_pkg.sv
// md_pos_pkg: shared FSM state type and count-saturation constants for the position cell streamer.
// No ports; imported by pos_cell_streamer.
package md_pos_pkg;
    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN} state_t;
    // Address 0 of the cell RAM holds the particle count, so pids run 1..PARTICLE_NUM-COUNT_RESERVED.
    localparam int COUNT_RESERVED = 1;
    function automatic int max_count(input int particle_num);
        return particle_num - COUNT_RESERVED;
    endfunction
endpackage

// File: rtl/pos_stream_fifo.sv
// pos_stream_fifo: synchronous FIFO with registered pointers, allowing simultaneous push and pop when full.
// Ports: clk, rst (async high); wr_en/wr_data push; rd_en pop; rd_data head word; full, empty, count occupancy.
module pos_stream_fifo #(
    parameter int WIDTH = 104,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    logic [PW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok, rd_ok;
    assign count   = wr_ptr - rd_ptr;
    assign empty   = count == '0;
    assign full    = count == (PW + 1)'(DEPTH);
    assign rd_ok   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr[PW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[PW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/pos_cell_streamer.sv
// pos_cell_streamer: reads a cell's particle count from RAM word 0, then streams words 1..count out with backpressure.
// Ports: clk, rst (async high); start/busy/done control; mem_address/mem_rden/mem_q external cell RAM read port;
// out_valid/out_ready/out_data/out_pid/out_last particle stream.
module pos_cell_streamer
    import md_pos_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(RD_LATENCY + 1);
    localparam logic [WW-1:0]         WAIT_LAST = WW'(RD_LATENCY - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_Q     = DATA_WIDTH'(max_count(PARTICLE_NUM));
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT   = ADDR_WIDTH'(max_count(PARTICLE_NUM));

    state_t                           state, state_nx;
    logic [WW-1:0]                    wait_cnt;
    logic [ADDR_WIDTH-1:0]            count, next_addr;
    logic [RD_LATENCY-1:0]            vld;
    logic [ADDR_WIDTH-1:0]            tag [RD_LATENCY];
    logic                             issue, finish, pop, credit;
    logic                             fifo_full, fifo_empty;
    logic [CW-1:0]                    fifo_count;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

    assign busy        = state != IDLE;
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign {out_pid, out_data} = head;
    assign out_last    = out_pid == count;
    // Reserve a FIFO slot for every read still in the RAM pipeline so returning words always fit.
    assign credit      = !fifo_full && (int'(fifo_count) + $countones(vld) < FIFO_DEPTH);
    assign mem_rden    = (state == RD_CNT) || issue;
    assign mem_address = issue ? next_addr : '0;

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE:     state_nx = start ? RD_CNT : IDLE;
            RD_CNT:   state_nx = WAIT_CNT;
            WAIT_CNT: state_nx = (wait_cnt == WAIT_LAST) ? STREAM : WAIT_CNT;
            STREAM: begin
                if (count == '0) begin
                    state_nx = IDLE;
                    finish   = 1'b1;
                end else if (credit) begin
                    issue    = 1'b1;
                    state_nx = (next_addr == count) ? DRAIN : STREAM;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_nx = IDLE;
                    finish   = 1'b1;
                end
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            wait_cnt  <= '0;
            count     <= '0;
            next_addr <= '0;
            vld       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) tag[i] <= '0;
        end else begin
            state    <= state_nx;
            done     <= finish;
            wait_cnt <= (state == WAIT_CNT) ? wait_cnt + 1'b1 : '0;
            // Saturate against the whole word so oversized counts clamp instead of wrapping.
            if (state == WAIT_CNT && wait_cnt == WAIT_LAST)
                count <= (mem_q > MAX_Q) ? MAX_CNT : mem_q[ADDR_WIDTH-1:0];
            if (state == RD_CNT)
                next_addr <= ADDR_WIDTH'(1);
            else if (issue)
                next_addr <= next_addr + 1'b1;
            vld[0] <= issue;
            tag[0] <= next_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    pos_stream_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld[RD_LATENCY-1]),
        .wr_data ({tag[RD_LATENCY-1], mem_q}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_pos_cell_streamer.sv
// tb_pos_cell_streamer: directed bench for pos_cell_streamer with a two-cycle cell RAM model.
module tb_pos_cell_streamer;
    localparam int DW = 96, PN = 220, AW = 8, RL = 2, FD = 4;

    logic          clk = 0, rst = 1, start = 0, out_ready = 1;
    logic          busy, done, mem_rden, out_valid, out_last;
    logic [AW-1:0] mem_address, out_pid, a_r;
    logic [DW-1:0] mem_q, out_data;
    logic [DW-1:0] ram [256];

    always #5 clk = ~clk;

    pos_cell_streamer #(
        .DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW), .RD_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_rden(mem_rden), .mem_q(mem_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pid(out_pid), .out_last(out_last)
    );

    // Registered address then registered output: q follows address by two cycles.
    always @(posedge clk) begin
        a_r   <= mem_address;
        mem_q <= ram[a_r];
    end

    function automatic logic [DW-1:0] word(input int i);
        return {32'(i * 7 + 3), 32'(i * 5 + 1), 32'(i + 1000)};
    endfunction

    int   cyc = 0;
    int   n, nvalid, ndone, nbusy, nlast, issued, max_out, ord_err;
    int   first_hs, last_hs, done_cyc, first_valid, start_cyc, exp_cnt;
    logic clr = 1;
    int   passed = 0, total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr) begin
            n = 0; nvalid = 0; ndone = 0; nbusy = 0; nlast = 0; issued = 0; max_out = 0; ord_err = 0;
            first_hs = -1; last_hs = -1; done_cyc = -1; first_valid = -1; start_cyc = -1;
        end else if (!rst) begin
            if (start && !busy && start_cyc < 0) start_cyc = cyc;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid) nvalid++;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (mem_rden && mem_address != 0) issued++;
            if (issued - n > max_out) max_out = issued - n;
            if (out_valid && out_ready) begin
                if (out_pid !== AW'(n + 1) || out_data !== word(n + 1) || out_last !== (n + 1 == exp_cnt))
                    ord_err++;
                if (out_last) nlast++;
                if (n == 0) first_hs = cyc;
                last_hs = cyc;
                n++;
            end
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic arm(input int cnt_word, input int exp);
        ram[0]  = DW'(cnt_word);
        exp_cnt = exp;
        clr     = 1;
        @(posedge clk); #1;
        clr     = 0;
        out_ready = 1;
        start   = 1;
        @(posedge clk); #1;
        start   = 0;
    endtask

    task automatic run_cell(input int cnt_word, input int exp, input bit tog, input bit extra_start);
        arm(cnt_word, exp);
        for (int i = 0; i < 2000 && ndone == 0; i++) begin
            @(posedge clk); #1;
            if (tog) out_ready = !out_ready;
            start = extra_start && (i == 2 || i == 8);
        end
        start = 0;
        out_ready = 1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 1; i < 256; i++) ram[i] = word(i);
        ram[0] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rden", mem_rden, 0);
        chk("rst_addr", mem_address, 0);
        rst = 0;

        run_cell(5, 5, 0, 0);
        chk("c5_words", n, 5);
        chk("c5_order", ord_err, 0);
        chk("c5_last", nlast, 1);
        chk("c5_back2back", last_hs - first_hs, 4);
        chk("c5_done_lat", done_cyc - last_hs, 1);
        chk("c5_done_cnt", ndone, 1);
        chk("c5_first_lat_ok", (first_valid - start_cyc) >= 2 * RL + 2, 1);

        run_cell(0, 0, 0, 0);
        chk("c0_words", n, 0);
        chk("c0_valid", nvalid, 0);
        chk("c0_done_cnt", ndone, 1);
        chk("c0_busy_cycles", nbusy, 2 + RL);

        run_cell(10, 10, 1, 0);
        chk("c10_words", n, 10);
        chk("c10_order", ord_err, 0);
        chk("c10_outstanding_ok", max_out <= FD, 1);
        chk("c10_done_cnt", ndone, 1);

        run_cell(300, PN - 1, 0, 0);
        chk("sat_words", n, PN - 1);
        chk("sat_order", ord_err, 0);
        chk("sat_last", nlast, 1);
        chk("sat_done_cnt", ndone, 1);

        arm(8, 8);
        for (int i = 0; i < 200 && !(out_valid && out_pid == 3); i++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_seen_pid", out_pid, 3);
        rst = 1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_mid_done", ndone, 0);
        run_cell(8, 8, 0, 0);
        chk("restart_words", n, 8);
        chk("restart_order", ord_err, 0);
        chk("restart_done_cnt", ndone, 1);

        run_cell(4, 4, 0, 1);
        chk("dup_start_words", n, 4);
        chk("dup_start_order", ord_err, 0);
        chk("dup_start_done_cnt", ndone, 1);
        chk("dup_start_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
